// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, and a
// mul/div result that loses arbitration is parked in a one-entry buffer.
module wb_port_arbiter #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            MdValid,
    input  logic [4:0]      MdRd,
    input  logic [XLEN-1:0] MdResult,
    output logic            MdReady,
    output logic            StallWB,
    output logic            RegWriteRF,
    output logic [4:0]      RdRF,
    output logic [XLEN-1:0] WDataRF,
    output logic            BufValid,
    output logic [4:0]      BufRd
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int unsigned RD_W   = 5;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [RD_W-1:0]     buf_rd_q, buf_rd_d;
    logic [XLEN-1:0]     buf_data_q, buf_data_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic held, pipe_wr, md_wr, force_drain, drain, squash, direct, md_ready, capture;

    // Arbitration terms; writes to x0 never compete for the port.
    always_comb begin
        held        = (state_q == HELD);
        pipe_wr     = RegWriteW && (RdW != '0);
        md_wr       = MdValid && (MdRd != '0);
        force_drain = held && (wait_q == WAIT_W'(MAX_WAIT));
        drain       = held && (force_drain || !pipe_wr);
        squash      = held && !force_drain && pipe_wr && (RdW == buf_rd_q);
        direct      = !held && !pipe_wr && md_wr;
        md_ready    = !held || drain;
        capture     = md_ready && md_wr && !direct;
    end

    // Port mux and handshake outputs, all quiet while reset is asserted.
    always_comb begin
        RegWriteRF = 1'b0;
        RdRF       = '0;
        WDataRF    = '0;
        MdReady    = 1'b0;
        StallWB    = 1'b0;
        if (!reset) begin
            MdReady = md_ready;
            StallWB = force_drain;
            if (drain) begin
                RegWriteRF = 1'b1;
                RdRF       = buf_rd_q;
                WDataRF    = buf_data_q;
            end else if (pipe_wr) begin
                RegWriteRF = 1'b1;
                RdRF       = RdW;
                WDataRF    = ResultW;
            end else if (direct) begin
                RegWriteRF = 1'b1;
                RdRF       = MdRd;
                WDataRF    = MdResult;
            end
        end
    end

    // Buffer next state: capture beats release; a younger pipeline write squashes.
    always_comb begin
        state_d    = state_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        wait_d     = wait_q;
        if (capture) begin
            state_d    = HELD;
            buf_rd_d   = MdRd;
            buf_data_d = MdResult;
            wait_d     = '0;
        end else if (drain || squash) begin
            state_d = EMPTY;
            wait_d  = '0;
        end else if (held && !force_drain) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            wait_q     <= wait_d;
        end
    end

    assign BufValid = held;
    assign BufRd    = buf_rd_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by random traffic,
// compared cycle by cycle against a rule-level model of the write port.
module tb_wb_port_arbiter;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned MAX_WAIT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            RegWriteW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;
    logic            MdValid;
    logic [4:0]      MdRd;
    logic [XLEN-1:0] MdResult;
    logic            MdReady, StallWB, RegWriteRF, BufValid;
    logic [4:0]      RdRF, BufRd;
    logic [XLEN-1:0] WDataRF;

    int checks = 0;
    int errors = 0;

    // Model state: the parked entry and its age in cycles since capture.
    bit              m_held;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    int              m_age;

    bit last_ready, last_stall;

    wb_port_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .MdValid(MdValid), .MdRd(MdRd), .MdResult(MdResult),
        .MdReady(MdReady), .StallWB(StallWB),
        .RegWriteRF(RegWriteRF), .RdRF(RdRF), .WDataRF(WDataRF),
        .BufValid(BufValid), .BufRd(BufRd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        MdValid   = 1'b0; MdRd = '0; MdResult = '0;
    endtask

    task automatic model_reset();
        m_held = 1'b0; m_rd = '0; m_data = '0; m_age = 0;
    endtask

    // One clock cycle: settle, compare against the model, clock, advance the model.
    task automatic cycle(input string tag);
        bit pw, mw, e_we, e_stall, e_ready, direct, freed, squash;
        logic [4:0]      e_rd;
        logic [XLEN-1:0] e_data;
        #1;
        pw = RegWriteW && (RdW != 5'd0);
        mw = MdValid && (MdRd != 5'd0);
        e_we = 1'b0; e_rd = '0; e_data = '0; e_stall = 1'b0;
        e_ready = 1'b1; direct = 1'b0; freed = 1'b0; squash = 1'b0;
        if (m_held && m_age >= int'(MAX_WAIT)) begin
            e_we = 1'b1; e_rd = m_rd; e_data = m_data; e_stall = 1'b1; freed = 1'b1;
        end else if (pw) begin
            e_we = 1'b1; e_rd = RdW; e_data = ResultW;
            if (m_held) begin
                e_ready = 1'b0;
                squash  = (RdW == m_rd);
            end
        end else if (m_held) begin
            e_we = 1'b1; e_rd = m_rd; e_data = m_data; freed = 1'b1;
        end else if (mw) begin
            e_we = 1'b1; e_rd = MdRd; e_data = MdResult; direct = 1'b1;
        end
        chk({tag, "_we"},    32'(RegWriteRF), 32'(e_we));
        chk({tag, "_rd"},    32'(RdRF),       32'(e_rd));
        chk({tag, "_data"},  WDataRF,         e_data);
        chk({tag, "_ready"}, 32'(MdReady),    32'(e_ready));
        chk({tag, "_stall"}, 32'(StallWB),    32'(e_stall));
        chk({tag, "_bufv"},  32'(BufValid),   32'(m_held));
        if (m_held) chk({tag, "_bufrd"}, 32'(BufRd), 32'(m_rd));
        last_ready = MdReady;
        last_stall = StallWB;
        @(posedge clk);
        if (e_ready && mw && !direct) begin
            m_held = 1'b1; m_rd = MdRd; m_data = MdResult; m_age = 0;
        end else if (freed || squash) begin
            m_held = 1'b0; m_age = 0;
        end else if (m_held) begin
            m_age++;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_we",    32'(RegWriteRF), 32'd0);
        chk("rst_ready", 32'(MdReady),    32'd0);
        chk("rst_stall", 32'(StallWB),    32'd0);
        chk("rst_bufv",  32'(BufValid),   32'd0);
        chk("rst_bufrd", 32'(BufRd),      32'd0);
        reset = 1'b0;

        // Direct write-through from an empty buffer.
        MdValid = 1'b1; MdRd = 5'd5; MdResult = 32'h1234;
        cycle("wthru");
        chk("wthru_bufv_after", 32'(BufValid), 32'd0);

        // Conflict: pipeline wins, mul/div parked, then opportunistic drain.
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hA;
        MdValid = 1'b1; MdRd = 5'd7; MdResult = 32'hB;
        cycle("conf");
        chk("conf_bufv", 32'(BufValid), 32'd1);
        chk("conf_bufrd", 32'(BufRd), 32'd7);
        idle();
        cycle("opdrain");
        chk("opdrain_bufv", 32'(BufValid), 32'd0);

        // Forced drain after MAX_WAIT cycles of back-to-back pipeline writes.
        RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h11;
        MdValid = 1'b1; MdRd = 5'd12; MdResult = 32'hC;
        cycle("fd_cap");
        MdValid = 1'b0; MdRd = '0; MdResult = '0;
        for (int i = 0; i <= int'(MAX_WAIT); i++) begin
            RdW = 5'(2 + i); ResultW = 32'(32'h100 + i);
            if (i == int'(MAX_WAIT)) begin
                #1;
                chk("fd_stall", 32'(StallWB), 32'd1);
                chk("fd_rd", 32'(RdRF), 32'd12);
            end
            cycle("fd_wait");
        end
        #1;
        chk("fd_grant_we", 32'(RegWriteRF), 32'd1);
        chk("fd_grant_rd", 32'(RdRF), 32'(2 + MAX_WAIT));
        chk("fd_grant_stall", 32'(StallWB), 32'd0);
        cycle("fd_grant");

        // WAW squash: younger pipeline write to the buffered destination.
        RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h22;
        MdValid = 1'b1; MdRd = 5'd9; MdResult = 32'hDEAD;
        cycle("waw_cap");
        MdValid = 1'b0; MdRd = '0; MdResult = '0;
        RdW = 5'd9; ResultW = 32'h55;
        cycle("waw_hit");
        idle();
        cycle("waw_after");
        chk("waw_bufv", 32'(BufValid), 32'd0);

        // x0 destinations.
        MdValid = 1'b1; MdRd = 5'd0; MdResult = 32'h77;
        cycle("md_x0");
        idle();
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h88;
        cycle("pipe_x0");

        // Random traffic under valid/ready and stall/hold discipline.
        idle();
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) begin
                RegWriteW = ($urandom_range(0, 99) < 55);
                RdW = ($urandom_range(0, 3) == 0 && m_held) ? m_rd : 5'($urandom_range(0, 31));
                ResultW = $urandom;
            end
            if (!(MdValid && !last_ready)) begin
                MdValid = ($urandom_range(0, 99) < 35);
                MdRd = 5'($urandom_range(0, 31));
                MdResult = $urandom;
            end
            cycle("rnd");
        end

        // Reset while HELD with two cycles of waiting.
        idle();
        cycle("pre_rst_idle");
        RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h1;
        MdValid = 1'b1; MdRd = 5'd20; MdResult = 32'h2020;
        cycle("rst_cap");
        MdValid = 1'b0; MdRd = '0; MdResult = '0;
        RdW = 5'd2; cycle("rst_w0");
        RdW = 5'd3; cycle("rst_w1");
        reset = 1'b1;
        #1;
        chk("midrst_bufv",  32'(BufValid),   32'd0);
        chk("midrst_ready", 32'(MdReady),    32'd0);
        chk("midrst_stall", 32'(StallWB),    32'd0);
        chk("midrst_we",    32'(RegWriteRF), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle();
        cycle("post_rst");
        // Fresh capture must wait the full MAX_WAIT again after reset.
        RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h3;
        MdValid = 1'b1; MdRd = 5'd21; MdResult = 32'h2121;
        cycle("post_cap");
        MdValid = 1'b0; MdRd = '0; MdResult = '0;
        for (int i = 0; i <= int'(MAX_WAIT); i++) begin
            RdW = 5'(2 + i);
            cycle("post_wait");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the pipeline write-back stage and the multi-cycle mul/div unit. Pipeline write-back has priority. A mul/div result that cannot be written immediately is parked in a one-entry holding buffer. The buffer drains into idle write-back slots, or after a bounded wait by stalling the pipeline for one cycle. The block sits between WBStage/the mul/div unit and the register file, and also feeds the hazard unit.

## Interface
Parameters:
- XLEN, 32, data width
- MAX_WAIT, 4, maximum cycles a buffered result waits before a forced drain (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- RegWriteW  in  1  pipeline WB write request
- RdW  in  5  pipeline WB destination
- ResultW  in  XLEN  pipeline WB data
- MdValid  in  1  mul/div result valid
- MdRd  in  5  mul/div destination
- MdResult  in  XLEN  mul/div data
- MdReady  out  1  mul/div result accepted this cycle (valid & ready = transfer)
- StallWB  out  1  hazard unit must hold the W-stage register and everything upstream this cycle
- RegWriteRF  out  1  register-file write enable
- RdRF  out  5  register-file write address
- WDataRF  out  XLEN  register-file write data
- BufValid  out  1  holding buffer occupied (for the hazard unit's scoreboard)
- BufRd  out  5  destination of the buffered result

## Operation
- State: BufValid/BufRd/BufData plus WaitCnt (width clog2(MAX_WAIT+1)). There are two states: EMPTY and HELD.
- PipeWr = RegWriteW & (RdW != 0). MdWr = MdValid & (MdRd != 0). Writes to x0 never reach the port; MdValid with MdRd=0 is accepted and discarded.
- Port selection, in priority order:
  1. Forced drain: HELD and WaitCnt == MAX_WAIT. The port writes the buffer and StallWB=1; the pipeline write is deferred, not lost.
  2. PipeWr: the port writes RdW/ResultW.
  3. HELD and no PipeWr: the port writes the buffer (opportunistic drain).
  4. EMPTY, no PipeWr, MdWr: direct write-through of MdRd/MdResult; the buffer stays EMPTY.
  5. Otherwise RegWriteRF=0. RdRF and WDataRF are then 0.
- MdReady = EMPTY, or buffer drains this cycle. Whenever MdReady & MdValid and the result was not written through directly, it is captured into the buffer. This capture applies in both EMPTY and drain cycles. WaitCnt is cleared on capture.
- HELD with no drain: WaitCnt increments, saturating at MAX_WAIT.
- WAW squash: HELD, not a forced-drain cycle, PipeWr, and RdW == BufRd. The pipeline instruction is younger, so the buffered entry is discarded at the edge: BufValid clears and nothing is written for it.
- A drain with no new capture → EMPTY with WaitCnt=0.
- Reset (asynchronous): BufValid=0, BufRd=0, BufData=0, WaitCnt=0. While reset is high, RegWriteRF, MdReady and StallWB are forced to 0.

## Timing
- Port outputs, MdReady and StallWB are combinational from the current inputs and state. The register file samples them at the next rising edge.
- Direct write-through has zero-cycle latency.
- Buffered result: written no later than MAX_WAIT+1 cycles after the capture edge.
- StallWB is high for exactly one cycle per forced drain. The held pipeline write is granted in the following cycle, since the buffer is then EMPTY or holds a fresh entry with WaitCnt=0.
- Simultaneous drain and capture: the old entry is written, the new entry is latched at the same edge, and WaitCnt=0.
- Simultaneous squash and capture is impossible, since MdReady=0 in a squash cycle (HELD, no drain).
- Reset asserted mid-HELD: the entry is lost. The mul/div unit is reset by the same signal.

## Test plan
- EMPTY, RegWriteW=0, MdValid=1, MdRd=5, MdResult=0x1234 → same cycle: RegWriteRF=1, RdRF=5, WDataRF=0x1234, MdReady=1; BufValid stays 0.
- RegWriteW=1, RdW=3, ResultW=0xA, plus MdValid=1, MdRd=7, MdResult=0xB → port writes x3=0xA; entry captured (BufValid=1, BufRd=7). Next cycle with RegWriteW=0 → port writes x7=0xB; BufValid=0.
- HELD with RegWriteW=1 to distinct Rds every cycle, MAX_WAIT=4 → WaitCnt 0,1,2,3,4. In the WaitCnt=4 cycle, StallWB=1 and the buffer is written. The held pipeline write is granted the next cycle with StallWB=0.
- HELD with BufRd=9, RegWriteW=1, RdW=9, ResultW=0x55 → x9=0x55 is written; BufValid=0 the next cycle; x9 is never written with the old value.
- MdValid=1, MdRd=0 in EMPTY → MdReady=1, RegWriteRF=0, BufValid stays 0. RegWriteW=1, RdW=0 → RegWriteRF=0.
- Assert reset while HELD with WaitCnt=2 → immediately BufValid=0, MdReady=0, StallWB=0, RegWriteRF=0. After release, the block is EMPTY with WaitCnt=0.
